// File: rtl/gemm_stream_engine.sv
// gemm_stream_engine: streams R = sat((alpha*(A x B) + beta*C) >>> FRAC_BITS)
// one output element at a time, LANES MACs per cycle along K, then one
// scale/saturate cycle per element. Operands are snapshotted on start.

// One multiply lane: signed DATA_WIDTH x DATA_WIDTH product, sign-extended
// to the accumulator width so lanes can be summed directly.
module gemm_mac_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 48
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [ACC_WIDTH-1:0]  o_prod
);
  logic signed [2*DATA_WIDTH-1:0] w_a_x, w_b_x, w_p;

  assign w_a_x  = {{DATA_WIDTH{i_a[DATA_WIDTH-1]}}, i_a};
  assign w_b_x  = {{DATA_WIDTH{i_b[DATA_WIDTH-1]}}, i_b};
  assign w_p    = w_a_x * w_b_x;
  assign o_prod = {{(ACC_WIDTH-2*DATA_WIDTH){w_p[2*DATA_WIDTH-1]}}, w_p};
endmodule

module gemm_stream_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 48,
  parameter int M          = 4,
  parameter int N          = 4,
  parameter int K          = 4,
  parameter int LANES      = 2,
  parameter int FRAC_BITS  = 0
) (
  input  logic                      iclk,
  input  logic                      irst_n,
  input  logic                      istart,
  input  logic                      iabort,
  input  logic [DATA_WIDTH-1:0]     ialpha,
  input  logic [DATA_WIDTH-1:0]     ibeta,
  input  logic [M*K*DATA_WIDTH-1:0] ia_matrix,
  input  logic [K*N*DATA_WIDTH-1:0] ib_matrix,
  input  logic [M*N*DATA_WIDTH-1:0] ic_matrix,
  output logic [M*N*DATA_WIDTH-1:0] oresult,
  output logic                      obusy,
  output logic                      odone,
  output logic                      osat
);
  localparam int KSTEPS = K / LANES;
  localparam int TW     = ACC_WIDTH + DATA_WIDTH + 1;
  localparam int IW     = (M > 1) ? $clog2(M) : 1;
  localparam int JW     = (N > 1) ? $clog2(N) : 1;
  localparam int SW     = $clog2(KSTEPS + 1);
  localparam int AW     = (M*K > 1) ? $clog2(M*K) : 1;
  localparam int BW     = (K*N > 1) ? $clog2(K*N) : 1;
  localparam int EW     = (M*N > 1) ? $clog2(M*N) : 1;

  localparam logic [IW-1:0] I_LAST = IW'(M - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N - 1);
  localparam logic [SW-1:0] S_LAST = SW'(KSTEPS);
  localparam logic signed [TW-1:0] SAT_MAX = {{(TW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [TW-1:0] SAT_MIN = {{(TW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [DATA_WIDTH-1:0]                r_alpha, r_beta;
  logic [M*K-1:0][DATA_WIDTH-1:0]       r_a;
  logic [K*N-1:0][DATA_WIDTH-1:0]       r_b;
  logic [M*N-1:0][DATA_WIDTH-1:0]       r_c;
  logic [M*N-1:0][DATA_WIDTH-1:0]       r_shadow, w_shadow_nxt;
  logic [M*N-1:0][DATA_WIDTH-1:0]       r_oresult;
  logic [ACC_WIDTH-1:0]                 r_acc;
  logic [IW-1:0]                        r_i;
  logic [JW-1:0]                        r_j;
  logic [SW-1:0]                        r_s, w_s_eff;
  logic                                 r_sat_pend, r_osat;

  logic                                 w_scale, w_last_elem;
  logic [EW-1:0]                        w_e;
  logic [LANES-1:0][ACC_WIDTH-1:0]      w_prod;
  logic [ACC_WIDTH-1:0]                 w_sum;
  logic signed [TW-1:0]                 w_alpha_x, w_beta_x, w_acc_x, w_c_x, w_t;
  logic [DATA_WIDTH-1:0]                w_res;
  logic                                 w_sat;

  assign oresult = r_oresult;
  assign obusy   = (r_state == S_COMPUTE);
  assign odone   = (r_state == S_DONE);
  assign osat    = r_osat;

  assign w_scale     = (r_s == S_LAST);
  assign w_last_elem = (r_i == I_LAST) && (r_j == J_LAST);
  // Keep operand indices in range during the scale cycle.
  assign w_s_eff     = w_scale ? '0 : r_s;
  assign w_e         = EW'(int'(r_i) * N + int'(r_j));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [AW-1:0] w_ai;
    logic [BW-1:0] w_bi;
    assign w_ai = AW'(int'(r_i) * K + int'(w_s_eff) * LANES + l);
    assign w_bi = BW'((int'(w_s_eff) * LANES + l) * N + int'(r_j));
    gemm_mac_lane #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane (
      .i_a    (r_a[w_ai]),
      .i_b    (r_b[w_bi]),
      .o_prod (w_prod[l])
    );
  end

  // Reduce the lane products into one accumulator increment.
  always_comb begin
    w_sum = '0;
    for (int l = 0; l < LANES; l++) w_sum = w_sum + w_prod[l];
  end

  // Scale at a width wide enough that alpha*acc + beta*c cannot overflow.
  assign w_alpha_x = {{(TW-DATA_WIDTH){r_alpha[DATA_WIDTH-1]}}, r_alpha};
  assign w_beta_x  = {{(TW-DATA_WIDTH){r_beta[DATA_WIDTH-1]}}, r_beta};
  assign w_acc_x   = {{(TW-ACC_WIDTH){r_acc[ACC_WIDTH-1]}}, r_acc};
  assign w_c_x     = {{(TW-DATA_WIDTH){r_c[w_e][DATA_WIDTH-1]}}, r_c[w_e]};
  assign w_t       = (w_alpha_x * w_acc_x + w_beta_x * w_c_x) >>> FRAC_BITS;

  // Clamp the scaled value to the element range and flag saturation.
  always_comb begin
    w_sat = 1'b0;
    w_res = w_t[DATA_WIDTH-1:0];
    if (w_t > SAT_MAX) begin
      w_sat = 1'b1;
      w_res = SAT_MAX[DATA_WIDTH-1:0];
    end else if (w_t < SAT_MIN) begin
      w_sat = 1'b1;
      w_res = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

  // Shadow array with the element being finished merged in.
  always_comb begin
    w_shadow_nxt      = r_shadow;
    w_shadow_nxt[w_e] = w_res;
  end

  // State register.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state; abort wins over the final scale cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (istart) w_state_nxt = S_COMPUTE;
      S_COMPUTE: begin
        if (iabort)                      w_state_nxt = S_IDLE;
        else if (w_scale && w_last_elem) w_state_nxt = S_DONE;
      end
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Operand snapshot, accumulate/scale datapath and result publication.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_alpha    <= '0;
      r_beta     <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_shadow   <= '0;
      r_oresult  <= '0;
      r_acc      <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_s        <= '0;
      r_sat_pend <= 1'b0;
      r_osat     <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (istart) begin
        r_alpha    <= ialpha;
        r_beta     <= ibeta;
        r_a        <= ia_matrix;
        r_b        <= ib_matrix;
        r_c        <= ic_matrix;
        r_acc      <= '0;
        r_i        <= '0;
        r_j        <= '0;
        r_s        <= '0;
        r_sat_pend <= 1'b0;
      end
    end else if (r_state == S_COMPUTE && !iabort) begin
      if (!w_scale) begin
        r_acc <= r_acc + w_sum;
        r_s   <= r_s + SW'(1);
      end else begin
        r_shadow   <= w_shadow_nxt;
        r_sat_pend <= r_sat_pend | w_sat;
        r_acc      <= '0;
        r_s        <= '0;
        if (w_last_elem) begin
          // Publish on the edge entering DONE so odone and data align.
          r_oresult <= w_shadow_nxt;
          r_osat    <= r_sat_pend | w_sat;
        end else if (r_j == J_LAST) begin
          r_j <= '0;
          r_i <= r_i + IW'(1);
        end else begin
          r_j <= r_j + JW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_gemm_stream_engine.sv
// Directed bench for gemm_stream_engine: a table of whole-job vectors plus
// hand-written sequences for back-to-back, abort, ignored start and reset.
module tb_gemm_stream_engine;
  localparam int DW = 16;
  localparam int MW = 16 * DW;

  logic          iclk = 1'b0, irst_n = 1'b0, istart = 1'b0, iabort = 1'b0;
  logic [DW-1:0] ialpha = '0, ibeta = '0;
  logic [MW-1:0] ia = '0, ib = '0, ic = '0;
  logic [MW-1:0] oresult, oresult_fx;
  logic          obusy, odone, osat, obusy_fx, odone_fx, osat_fx;

  always #5 iclk = ~iclk;

  gemm_stream_engine #(.FRAC_BITS(0)) dut (
    .iclk(iclk), .irst_n(irst_n), .istart(istart), .iabort(iabort),
    .ialpha(ialpha), .ibeta(ibeta), .ia_matrix(ia), .ib_matrix(ib), .ic_matrix(ic),
    .oresult(oresult), .obusy(obusy), .odone(odone), .osat(osat));

  gemm_stream_engine #(.FRAC_BITS(8)) dut_fx (
    .iclk(iclk), .irst_n(irst_n), .istart(istart), .iabort(iabort),
    .ialpha(ialpha), .ibeta(ibeta), .ia_matrix(ia), .ib_matrix(ib), .ic_matrix(ic),
    .oresult(oresult_fx), .obusy(obusy_fx), .odone(odone_fx), .osat(osat_fx));

  typedef struct {
    string         name;
    logic [DW-1:0] alpha, beta;
    logic [MW-1:0] a, b, c, exp;
    logic          exp_sat;
    bit            fx;
  } vec_t;

  vec_t tv[7];
  int   n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [MW-1:0] got, input logic [MW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic chk_i(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [DW-1:0] al, input logic [DW-1:0] be,
                              input logic [MW-1:0] a, input logic [MW-1:0] b, input logic [MW-1:0] c,
                              input logic [MW-1:0] e, input logic s, input bit fx);
    vec_t v;
    v.name = nm; v.alpha = al; v.beta = be; v.a = a; v.b = b; v.c = c;
    v.exp = e; v.exp_sat = s; v.fx = fx;
    return v;
  endfunction

  task automatic apply_ops(input vec_t v);
    ialpha = v.alpha; ibeta = v.beta; ia = v.a; ib = v.b; ic = v.c;
  endtask

  // Operands are only meaningful on the accepting edge; disturb them after.
  task automatic scramble();
    ialpha = ~ialpha; ibeta = ~ibeta; ia = ~ia; ib = ~ib; ic = ~ic;
  endtask

  task automatic start_job(input vec_t v);
    apply_ops(v);
    istart = 1'b1;
    @(posedge iclk);
    @(negedge iclk);
    istart = 1'b0;
    scramble();
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!odone && cyc < 200) begin
      @(negedge iclk);
      cyc++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [MW-1:0] a_id, a_id256, a_zero, b_seq, c_neg, r_2c, all_7fff, all_8000, all_3, all_m3, all_1234;
    int cyc, seen;

    a_zero = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int idx;
        idx = (r * 4 + c) * DW;
        a_id[idx +: DW]     = (r == c) ? 16'd1 : 16'd0;
        a_id256[idx +: DW]  = (r == c) ? 16'd256 : 16'd0;
        b_seq[idx +: DW]    = 16'(r * 4 + c);
        c_neg[idx +: DW]    = 16'(-(r * 4 + c));
        r_2c[idx +: DW]     = 16'(-2 * (r * 4 + c));
        all_7fff[idx +: DW] = 16'h7FFF;
        all_8000[idx +: DW] = 16'h8000;
        all_3[idx +: DW]    = 16'd3;
        all_m3[idx +: DW]   = 16'hFFFD;
        all_1234[idx +: DW] = 16'h1234;
      end
    end

    tv[0] = mk("identity", 16'd1, 16'd0, a_id,     b_seq,    a_zero, b_seq,    1'b0, 1'b0);
    tv[1] = mk("addend",   16'd0, 16'd2, all_1234, all_1234, c_neg,  r_2c,     1'b0, 1'b0);
    tv[2] = mk("sat_pos",  16'd1, 16'd0, all_7fff, all_7fff, a_zero, all_7fff, 1'b1, 1'b0);
    tv[3] = mk("sat_clr",  16'd1, 16'd0, a_zero,   all_7fff, a_zero, a_zero,   1'b0, 1'b0);
    tv[4] = mk("sat_neg",  16'd1, 16'd0, all_8000, all_7fff, a_zero, all_8000, 1'b1, 1'b0);
    tv[5] = mk("fx_pos",   16'd1, 16'd0, a_id256,  all_3,    a_zero, all_3,    1'b0, 1'b1);
    tv[6] = mk("fx_neg",   16'd1, 16'd0, a_id256,  all_m3,   a_zero, all_m3,   1'b0, 1'b1);

    // Reset state
    repeat (2) @(negedge iclk);
    chk("reset_result", oresult, '0);
    chk_i("reset_flags", int'({obusy, odone, osat}), 0);
    chk("reset_result_fx", oresult_fx, '0);
    irst_n = 1'b1;
    @(negedge iclk);

    // Table-driven whole jobs
    for (int i = 0; i < 7; i++) begin
      start_job(tv[i]);
      chk_i({tv[i].name, "/busy"}, int'(obusy), 1);
      wait_done(cyc);
      chk_i({tv[i].name, "/cycles"}, cyc, 48);
      if (tv[i].fx) begin
        chk({tv[i].name, "/result"}, oresult_fx, tv[i].exp);
        chk_i({tv[i].name, "/sat"}, int'(osat_fx), int'(tv[i].exp_sat));
      end else begin
        chk({tv[i].name, "/result"}, oresult, tv[i].exp);
        chk_i({tv[i].name, "/sat"}, int'(osat), int'(tv[i].exp_sat));
      end
      @(negedge iclk);
      chk_i({tv[i].name, "/done_pulse"}, int'({odone, obusy}), 0);
    end

    // istart pulses during COMPUTE (with different operands) are ignored
    start_job(tv[2]);
    cyc = 0;
    while (!odone && cyc < 200) begin
      istart = (cyc == 5 || cyc == 20);
      if (istart) apply_ops(tv[0]);
      @(negedge iclk);
      cyc++;
    end
    istart = 1'b0;
    chk_i("ignore_start/cycles", cyc, 48);
    chk("ignore_start/result", oresult, tv[2].exp);
    chk_i("ignore_start/sat", int'(osat), 1);
    @(negedge iclk);

    // Abort in cycle 10 of COMPUTE: busy drops, no done, outputs kept
    start_job(tv[0]);
    repeat (9) @(negedge iclk);
    iabort = 1'b1;
    @(negedge iclk);
    iabort = 1'b0;
    chk_i("abort/busy_drop", int'(obusy), 0);
    seen = 0;
    repeat (60) begin
      @(negedge iclk);
      if (odone || obusy) seen++;
    end
    chk_i("abort/no_done", seen, 0);
    chk("abort/result_kept", oresult, tv[2].exp);
    chk_i("abort/sat_kept", int'(osat), 1);

    // Asynchronous reset mid-job clears everything immediately
    start_job(tv[0]);
    repeat (19) @(negedge iclk);
    #2 irst_n = 1'b0;
    #1;
    chk("async_rst/result", oresult, '0);
    chk_i("async_rst/flags", int'({obusy, odone, osat}), 0);
    @(negedge iclk);
    irst_n = 1'b1;
    @(negedge iclk);
    chk_i("async_rst/idle", int'(obusy), 0);
    start_job(tv[0]);
    wait_done(cyc);
    chk_i("after_rst/cycles", cyc, 48);
    chk("after_rst/result", oresult, tv[0].exp);
    chk_i("after_rst/sat", int'(osat), 0);

    // Back-to-back: istart held through DONE is taken on the first IDLE cycle
    apply_ops(tv[1]);
    istart = 1'b1;
    chk_i("b2b/busy_in_done", int'(obusy), 0);
    @(negedge iclk);
    chk_i("b2b/idle_gap", int'({obusy, odone}), 0);
    @(negedge iclk);
    chk_i("b2b/accept", int'(obusy), 1);
    istart = 1'b0;
    scramble();
    wait_done(cyc);
    chk_i("b2b/cycles", cyc, 48);
    chk("b2b/result", oresult, tv[1].exp);
    @(negedge iclk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/gemm_stream_engine.md
# gemm_stream_engine

Parametrised successor GEMM engine computing R = sat((alpha·(A×B) + beta·C) >>> FRAC_BITS) for an M×K by K×N product with an M×N addend. Operands and scalars are snapshotted on start, so sources may change while the engine runs. LANES multiply-accumulate lanes consume K in chunks per cycle. The block adds fixed-point scaling, saturation reporting and abort, and sits as a compute leaf under the system controller that drives istart.

## Interface
Parameters:
- DATA_WIDTH, 16, signed element, alpha and beta width
- ACC_WIDTH, 48, signed accumulator width; must be ≥ 2·DATA_WIDTH + clog2(K)
- M, 4, rows of A, C and R
- N, 4, columns of B, C and R
- K, 4, inner dimension
- LANES, 2, MACs per cycle; must divide K
- FRAC_BITS, 0, arithmetic right shift applied after scaling

Ports (flat packing: element (r,c) of an X-column matrix occupies bits [(r·X+c)·DATA_WIDTH +: DATA_WIDTH]):
- iclk  in  1  clock, rising edge
- irst_n  in  1  asynchronous active-low reset
- istart  in  1  start request; sampled only in IDLE
- iabort  in  1  abort request; sampled only in COMPUTE
- ialpha, ibeta  in  DATA_WIDTH each  signed scalars
- ia_matrix  in  M·K·DATA_WIDTH  A, row-major
- ib_matrix  in  K·N·DATA_WIDTH  B, row-major
- ic_matrix  in  M·N·DATA_WIDTH  C, row-major
- oresult  out  M·N·DATA_WIDTH  R, row-major, registered
- obusy  out  1  high in COMPUTE
- odone  out  1  one-cycle pulse in DONE
- osat  out  1  sticky: some element of the last completed job saturated

## Operation
- Arithmetic is signed two's-complement throughout.
- State IDLE:
  - When istart = 1, capture alpha, beta, A, B and C into internal registers.
  - Clear osat_pending, zero the accumulator, set element index e = 0 (i = e / N, j = e % N) and step s = 0.
  - Go to COMPUTE.
- State COMPUTE, step s < KSTEPS (KSTEPS = K/LANES):
  - acc += Σ over l in 0..LANES-1 of A[i][s·LANES+l] · B[s·LANES+l][j].
- State COMPUTE, step s = KSTEPS (SCALE cycle):
  - Form t = (alpha·acc + beta·C[i][j]) >>> FRAC_BITS at width ACC_WIDTH + DATA_WIDTH + 1.
  - Clamp t to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] and write the result into the shadow result array.
  - If the clamp engaged, set osat_pending.
  - Zero acc and set s = 0.
  - If e = M·N−1, go to DONE; otherwise e++.
- State DONE:
  - Copy the shadow array to oresult, set osat = osat_pending, assert odone.
  - Go to IDLE.
- Abort: iabort = 1 in COMPUTE returns the engine to IDLE on the next edge. No odone pulse; oresult and osat keep the previous job's values. iabort has priority over a SCALE-cycle transition to DONE.
- istart is ignored outside IDLE. No queueing.
- There are no other states. Encoding of an unused state recovers to IDLE.

## Timing
- Reset (irst_n = 0, asynchronous):
  - state = IDLE; oresult, obusy, odone and osat = 0; all internal registers = 0.
  - Deassertion is synchronised externally.
- Start and busy:
  - istart sampled high at edge T0 → obusy = 1 from T0.
  - obusy stays high for M·N·(KSTEPS+1) cycles; with the defaults that is 48.
  - odone = 1 for the single following cycle; oresult and osat are valid from the same edge.
- Back-to-back jobs:
  - istart held high through DONE is not accepted in DONE.
  - It is accepted on the first IDLE cycle, giving a one-idle-cycle minimum gap between jobs.
- Reset mid-job aborts immediately; all outputs go to 0.
- Operand inputs are don't-care except on the accepting edge.

## Test plan
- Identity (defaults): A = I, B = arbitrary with B[r][c] = r·4+c, C = 0, alpha = 1, beta = 0 → oresult = B; odone exactly 48 cycles after start; osat = 0.
- Addend only: alpha = 0, beta = 2, C[r][c] = −r·4−c → R[r][c] = 2·C[r][c]; A and B are ignored.
- Saturation: all of A and B = 0x7FFF, alpha = 1 → every element = 0x7FFF; osat = 1. A repeat job with A = 0 → osat = 0.
- Fixed point: FRAC_BITS = 8, A = I·256, B[r][c] = 3 (B entries, not scalars), alpha = 1, beta = 0 → R = 3 everywhere. Negative case: B = −3 → R = −3, not −2 (arithmetic shift exact).
- Abort and ignore:
  - Assert iabort in cycle 10 of COMPUTE → obusy drops next cycle, no odone, oresult unchanged.
  - istart pulses during COMPUTE are ignored; job length stays 48.
- Async reset mid-job: drop irst_n between edges at cycle 20 → all outputs 0 immediately. A new istart after release completes with the correct result.
